keypad_scanner: RTL and testbench

Matrix-scan reader for a 4x4 active-low keypad: drives one column low at a time, samples the four row lines, debounces, and reports one hex key code per press. It is the input-side counterpart of the multiplexed seven-segment driver. That driver scans anodes outward; this block scans columns and reads inward. Its `key_code` is in the same 0-F range, so it feeds the display decoder directly.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_sync.sv | 31 +++
 rtl/keypad_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and the key map for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } kp_state_t;

   localparam logic [3:0] KP_IDLE_COL = 4'b1110;

   // Row 0 is the top row, column 0 the leftmost column.
   function automatic logic [3:0] kp_keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'h0;
      case ({row, col})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'h0;
         4'hD: code = 4'hF;
         4'hE: code = 4'hE;
         4'hF: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer; resets to all ones so idle (pulled-up) rows read high.
module keypad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_d, meta_q;
   logic [WIDTH-1:0] sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad matrix scanner with press/release debounce.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SCAN     | sweep columns, look for any low row on each strobe
//   DEBOUNCE | column frozen, counting agreeing low samples of captured row
//   HELD     | key reported, counting consecutive high samples for release
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100_000,
   parameter int DEBOUNCE_SCANS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0] row_s;

   kp_state_t        state_d, state_q;
   logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
   logic [1:0]       col_d, col_q;
   logic [1:0]       row_d, row_q;
   logic [CNT_W-1:0] match_cnt_d, match_cnt_q;
   logic [CNT_W-1:0] rel_cnt_d, rel_cnt_q;
   logic [3:0]       key_code_d, key_code_q;
   logic             key_valid_d, key_valid_q;
   logic             key_held_d, key_held_q;

   logic       strobe;
   logic       any_low;
   logic [1:0] hit_row;
   logic       cap_low;

   keypad_sync #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_n),
      .q   (row_s)
   );

   always_comb begin
      strobe    = (div_cnt_q == DIV_LAST);
      div_cnt_d = strobe ? '0 : div_cnt_q + DIV_ONE;
   end

   // Lowest-index low row wins when several rows read low.
   always_comb begin
      hit_row = 2'd0;
      any_low = ~&row_s;
      if (!row_s[0])      hit_row = 2'd0;
      else if (!row_s[1]) hit_row = 2'd1;
      else if (!row_s[2]) hit_row = 2'd2;
      else if (!row_s[3]) hit_row = 2'd3;
      cap_low = ~row_s[row_q];
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      match_cnt_d = match_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      case (state_q)
         SCAN: begin
            if (strobe) begin
               if (any_low) begin
                  row_d = hit_row;
                  if (DEBOUNCE_SCANS == 1) begin
                     key_code_d  = kp_keymap(hit_row, col_q);
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     match_cnt_d = '0;
                     rel_cnt_d   = '0;
                     state_d     = HELD;
                  end else begin
                     match_cnt_d = CNT_ONE;
                     state_d     = DEBOUNCE;
                  end
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end

         DEBOUNCE: begin
            if (strobe) begin
               if (cap_low) begin
                  if (match_cnt_q + CNT_ONE == CNT_DONE) begin
                     key_code_d  = kp_keymap(row_q, col_q);
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                     match_cnt_d = '0;
                     rel_cnt_d   = '0;
                     state_d     = HELD;
                  end else begin
                     match_cnt_d = match_cnt_q + CNT_ONE;
                  end
               end else begin
                  match_cnt_d = '0;
                  col_d       = col_q + 2'd1;
                  state_d     = SCAN;
               end
            end
         end

         HELD: begin
            // Only the captured row in the frozen column matters here.
            if (strobe) begin
               if (!cap_low) begin
                  if (rel_cnt_q + CNT_ONE == CNT_DONE) begin
                     rel_cnt_d  = '0;
                     key_held_d = 1'b0;
                     col_d      = col_q + 2'd1;
                     state_d    = SCAN;
                  end else begin
                     rel_cnt_d = rel_cnt_q + CNT_ONE;
                  end
               end else begin
                  rel_cnt_d = '0;
               end
            end
         end

         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         div_cnt_q   <= '0;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         match_cnt_q <= '0;
         rel_cnt_q   <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         match_cnt_q <= match_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign col_n     = (col_q == 2'd0) ? KP_IDLE_COL : ~(4'b0001 << col_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a physical keypad matrix model.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DS = 3;

   logic       clk;
   logic       rst;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [15:0] key_dn;

   int checks;
   int errors;
   int vcount;
   int ph;

   typedef struct {
      int         row;
      int         col;
      logic [3:0] code;
   } vec_t;

   vec_t tbl [16];

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key shorts its row to its column; a row reads low when any
   // pressed key on it sits in the column currently driven low.
   always_comb begin
      for (int r = 0; r < 4; r++)
         row_n[r] = ~|(key_dn[r*4 +: 4] & ~col_n);
   end

   // Reference strobe phase: phase SD-1 is a strobe cycle.
   always @(posedge clk) ph <= rst ? 0 : ((ph == SD-1) ? 0 : ph + 1);

   always @(negedge clk) if (key_valid === 1'b1) vcount <= vcount + 1;

   function automatic logic [3:0] col_mask(input int c);
      case (c)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic press(input int r, input int c);
      key_dn[r*4+c] = 1'b1;
   endtask

   // Returns #1 after the edge that closes the next strobe cycle.
   task automatic next_strobe_edge();
      for (int i = 0; i < 2*SD; i++) begin
         @(negedge clk);
         if (ph == SD-1) break;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic align_col(input int c);
      for (int i = 0; i < 8; i++) begin
         next_strobe_edge();
         if (col_n == col_mask(c)) break;
      end
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_fall(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int v0;
      int first;
      bit found;

      checks = 0;
      errors = 0;
      vcount = 0;
      key_dn = '0;
      rst    = 1'b1;

      tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2};
      tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
      tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5};
      tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
      tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8};
      tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
      tbl[12] = '{3, 0, 4'h0}; tbl[13] = '{3, 1, 4'hF};
      tbl[14] = '{3, 2, 4'hE}; tbl[15] = '{3, 3, 4'hD};

      // Reset and idle sweep
      repeat (3) @(posedge clk);
      #1;
      chk("rst_col_n", col_n, 4'b1110);
      chk("rst_code", key_code, 4'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      rst = 1'b0;
      for (int n = 0; n <= 16; n++) begin
         @(negedge clk);
         chk("idle_col_n", col_n, col_mask((n / 4) % 4));
      end
      #1;
      chk("idle_no_valid", vcount, 0);
      chk("idle_code", key_code, 4'h0);

      // Every key, one at a time
      for (int i = 0; i < 16; i++) begin
         press(tbl[i].row, tbl[i].col);
         wait_valid(60, ok);
         chk("tbl_valid_seen", ok, 1'b1);
         chk("tbl_code", key_code, tbl[i].code);
         chk("tbl_held", key_held, 1'b1);
         chk("tbl_col_frozen", col_n, col_mask(tbl[i].col));
         @(negedge clk);
         chk("tbl_valid_one_cycle", key_valid, 1'b0);
         key_dn = '0;
         wait_fall(40, ok);
         chk("tbl_release_seen", ok, 1'b1);
         chk("tbl_col_next", col_n, col_mask((tbl[i].col + 1) % 4));
      end

      // Clean press "5": exact latency and release
      align_col(0);
      press(1, 1);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ph == SD-1 && col_n == col_mask(1)) begin
            found = 1'b1;
            break;
         end
      end
      chk("p5_detect_strobe", found, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("p5_valid_timing", key_valid, (k == 9) ? 1'b1 : 1'b0);
         if (k == 9) begin
            chk("p5_code", key_code, 4'h5);
            chk("p5_held", key_held, 1'b1);
         end
      end
      next_strobe_edge();
      key_dn = '0;
      next_strobe_edge();
      chk("p5_rel1_held", key_held, 1'b1);
      next_strobe_edge();
      chk("p5_rel2_held", key_held, 1'b1);
      chk("p5_rel2_col", col_n, col_mask(1));
      next_strobe_edge();
      chk("p5_rel3_held", key_held, 1'b0);
      chk("p5_resume_col2", col_n, col_mask(2));

      // Bounce on "D", then a stable press
      align_col(3);
      press(3, 3);
      v0 = vcount;
      next_strobe_edge();
      chk("bounce_col_frozen", col_n, col_mask(3));
      key_dn = '0;
      next_strobe_edge();
      chk("bounce_col_adv", col_n, col_mask(0));
      repeat (20) @(negedge clk);
      #1;
      chk("bounce_no_valid", vcount - v0, 0);
      chk("bounce_not_held", key_held, 1'b0);
      press(3, 3);
      wait_valid(60, ok);
      chk("d_valid_seen", ok, 1'b1);
      chk("d_code", key_code, 4'hD);
      key_dn = '0;
      wait_fall(40, ok);
      chk("d_release_seen", ok, 1'b1);

      // Multi-row priority, and other keys ignored while held
      press(0, 0);
      press(2, 0);
      wait_valid(60, ok);
      chk("multi_valid_seen", ok, 1'b1);
      chk("multi_code", key_code, 4'h1);
      key_dn[8] = 1'b0;
      repeat (8) @(negedge clk);
      key_dn[8] = 1'b1;
      v0 = vcount;
      repeat (40) @(negedge clk);
      #1;
      chk("multi_no_second", vcount - v0, 0);
      chk("multi_still_held", key_held, 1'b1);
      chk("multi_code_kept", key_code, 4'h1);
      key_dn = '0;
      wait_fall(40, ok);
      chk("multi_release_seen", ok, 1'b1);

      // Release glitch: high 2, low 1, high 3
      press(2, 2);
      wait_valid(60, ok);
      chk("glitch_valid_seen", ok, 1'b1);
      chk("glitch_code", key_code, 4'h9);
      @(negedge clk);
      v0 = vcount;
      next_strobe_edge();
      key_dn = '0;
      next_strobe_edge();
      chk("glitch_h1", key_held, 1'b1);
      next_strobe_edge();
      chk("glitch_h2", key_held, 1'b1);
      press(2, 2);
      next_strobe_edge();
      chk("glitch_low", key_held, 1'b1);
      key_dn = '0;
      next_strobe_edge();
      chk("glitch_h1b", key_held, 1'b1);
      next_strobe_edge();
      chk("glitch_h2b", key_held, 1'b1);
      next_strobe_edge();
      chk("glitch_h3b", key_held, 1'b0);
      chk("glitch_col_adv", col_n, col_mask(3));
      chk("glitch_no_valid", vcount - v0, 0);

      // Reset while match_cnt = 2, key kept down
      align_col(0);
      press(0, 1);
      next_strobe_edge();
      next_strobe_edge();
      chk("rstmid_col_frozen_pre", col_n, col_mask(1));
      next_strobe_edge();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid_col_n", col_n, 4'b1110);
      chk("rstmid_code", key_code, 4'h0);
      chk("rstmid_valid", key_valid, 1'b0);
      chk("rstmid_held", key_held, 1'b0);
      v0 = vcount;
      rst = 1'b0;
      first = -1;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk);
         if (key_valid === 1'b1 && first < 0) first = k;
      end
      #1;
      chk("rstmid_one_pulse", vcount - v0, 1);
      chk("rstmid_pulse_cycle", first, 16);
      chk("rstmid_code_after", key_code, 4'h2);
      chk("rstmid_held_after", key_held, 1'b1);
      key_dn = '0;
      wait_fall(40, ok);
      chk("rstmid_release_seen", ok, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
